// File: rtl/screen_scanner.sv
// Raster scanner: fetches the 256-byte 64x32 monochrome framebuffer one byte at a time
// and streams each byte out as eight pixels over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | waiting for mem_grant to issue the read for byte idx
// WAIT    | read strobe cycle, then data cycle; byte captured at the end of the data cycle
// SHIFT   | presenting pixel bit of byte idx until accepted
module screen_scanner #(
    parameter logic [15:0] SCREEN_START = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic        mem_grant,
    output logic        mem_read,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_read_byte,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        pixel,
    output logic [5:0]  pixel_x,
    output logic [4:0]  pixel_y,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        mem_read_q, mem_read_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 8'd0;
            bit_q        <= 3'd0;
            shreg_q      <= 8'd0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        mem_read_d   = 1'b0;
        mem_addr_d   = 16'd0;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = 8'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_grant) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = SCREEN_START + {8'd0, idx_q};
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // mem_read_q is high only during the strobe cycle; data arrives the cycle after
                if (!mem_read_q) begin
                    shreg_d = mem_read_byte;
                    bit_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (pixel_ready) begin
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                    end else if (idx_q != 8'hFF) begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_FETCH;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;
    assign frame_done  = frame_done_q;
    assign pixel_valid = (state_q == S_SHIFT);
    // MSB of each byte is the leftmost pixel
    assign pixel       = pixel_valid & shreg_q[~bit_q];
    assign pixel_x     = pixel_valid ? {idx_q[2:0], bit_q} : 6'd0;
    assign pixel_y     = pixel_valid ? idx_q[7:3] : 5'd0;

endmodule

// File: tb/tb_screen_scanner.sv
// Scoreboard bench for screen_scanner: a byte fetch pushes its eight expected pixels,
// every accepted pixel pops and compares; frame-level counts and timing checked per frame.
module tb_screen_scanner;
    localparam logic [15:0] SS = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        mem_grant;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [7:0]  mem_read_byte;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel;
    logic [5:0]  pixel_x;
    logic [4:0]  pixel_y;
    logic        frame_done;

    screen_scanner #(.SCREEN_START(SS)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .mem_grant     (mem_grant),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_read_byte (mem_read_byte),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .pixel         (pixel),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
        logic       v;
    } pix_t;

    pix_t       sb_q[$];
    pix_t       mon_p, exp_p, hold_p;
    logic [7:0] fb [256];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         rd_cnt  = 0;
    int         pix_cnt = 0;
    int         lit_cnt = 0;
    int         fd_cnt  = 0;
    int         fd_base = 0;
    int         fd_cyc  = 0;
    int         first_cyc = -1;
    int         t0      = 0;
    bit         hold_v  = 1'b0;
    logic       rd_pend = 1'b0;
    logic [7:0] rd_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory: data driven only during the cycle after the strobe, junk otherwise
    always begin
        @(posedge clk);
        #1;
        mem_read_byte = rd_pend ? rd_data : 8'hA5;
        rd_pend = mem_read;
        if (mem_read) rd_data = fb[mem_addr[7:0]];
    end

    always @(negedge clk) begin
        if (mem_read) begin
            check("rd_addr", mem_addr, SS + 16'(rd_cnt));
            for (int b = 0; b < 8; b++) begin
                mon_p.x = 6'(((rd_cnt % 8) * 8) + b);
                mon_p.y = 5'(rd_cnt / 8);
                mon_p.v = fb[rd_cnt[7:0]][7-b];
                sb_q.push_back(mon_p);
            end
            rd_cnt++;
        end
        if (pixel_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (hold_v) begin
                check("hold_x", pixel_x, hold_p.x);
                check("hold_y", pixel_y, hold_p.y);
                check("hold_pix", pixel, hold_p.v);
            end
            if (pixel_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_extra_pixel", 1, 0);
                end else begin
                    exp_p = sb_q.pop_front();
                    check("pix_x", pixel_x, exp_p.x);
                    check("pix_y", pixel_y, exp_p.y);
                    check("pix_val", pixel, exp_p.v);
                end
                pix_cnt++;
                if (pixel) lit_cnt++;
                hold_v = 1'b0;
            end else begin
                hold_v   = 1'b1;
                hold_p.x = pixel_x;
                hold_p.y = pixel_y;
                hold_p.v = pixel;
            end
        end else if (hold_v) begin
            check("hold_valid", 0, 1);
            hold_v = 1'b0;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_pixel_valid"}, pixel_valid, 0);
        check({tag, "_pixel"}, pixel, 0);
        check({tag, "_pixel_x"}, pixel_x, 0);
        check({tag, "_pixel_y"}, pixel_y, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic start_frame();
        rd_cnt    = 0;
        pix_cnt   = 0;
        lit_cnt   = 0;
        first_cyc = -1;
        fd_base   = fd_cnt;
        sb_q.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    // mode 0: free-running, 1: stall + grant gap, 2: random handshake + restart, 3: reset at (20,4)
    task automatic run_frame(input int mode, input int budget);
        int n     = 0;
        int stall = 0;
        int gl    = 0;
        bit did_stall = 1'b0;
        bit did_gl    = 1'b0;
        bit gret      = 1'b0;
        bit done      = 1'b0;
        while (!done && fd_cnt == fd_base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            case (mode)
                1: begin
                    if (stall > 0) begin
                        check("stall_valid", pixel_valid, 1);
                        check("stall_x", pixel_x, 3);
                        check("stall_y", pixel_y, 0);
                        stall--;
                        if (stall == 0) pixel_ready = 1'b1;
                    end else if (!did_stall && pixel_valid && pixel_x == 6'd3 && pixel_y == 5'd0) begin
                        did_stall   = 1'b1;
                        stall       = 5;
                        pixel_ready = 1'b0;
                    end
                    if (gl > 0) begin
                        check("gnt_low_noread", mem_read, 0);
                        gl--;
                        if (gl == 0) begin
                            mem_grant = 1'b1;
                            gret      = 1'b1;
                        end
                    end else if (gret) begin
                        gret = 1'b0;
                        check("gnt_back_read", mem_read, 1);
                        check("gnt_back_addr", mem_addr, SS + 16'h0002);
                    end else if (!did_gl && pixel_valid && pixel_ready && pixel_x == 6'd15 && pixel_y == 5'd0) begin
                        did_gl    = 1'b1;
                        mem_grant = 1'b0;
                        gl        = 11;
                    end
                end
                2: begin
                    pixel_ready = ($urandom_range(0, 3) != 0);
                    mem_grant   = ($urandom_range(0, 3) != 0);
                    start       = (n == 500);
                    if (n == 300) fb[200] = 8'h3C;
                end
                3: begin
                    if (pixel_valid && pixel_x == 6'd20 && pixel_y == 5'd4) begin
                        #2;
                        reset = 1'b1;
                        #1;
                        check_zero("rst_mid");
                        sb_q.delete();
                        rd_cnt = 0;
                        hold_v = 1'b0;
                        @(posedge clk);
                        #1;
                        reset = 1'b0;
                        repeat (5) @(posedge clk);
                        #1;
                        check("rst_no_restart", busy, 0);
                        check("rst_no_frame_done", fd_cnt - fd_base, 0);
                        done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (!done) check("frame_timeout", fd_cnt != fd_base, 1);
        if (mode == 1) begin
            check("stall_hit", did_stall, 1);
            check("gnt_gap_hit", did_gl, 1);
        end
        if (mode == 3) check("rst_point_hit", done, 1);
        pixel_ready = 1'b1;
        mem_grant   = 1'b1;
        start       = 1'b0;
    endtask

    task automatic end_checks(input int exp_lit, input bit timing);
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_count", fd_cnt - fd_base, 1);
        check("pix_count", pix_cnt, 2048);
        check("lit_count", lit_cnt, exp_lit);
        check("read_count", rd_cnt, 256);
        check("sb_left", sb_q.size(), 0);
        check("busy_after", busy, 0);
        if (timing) begin
            check("first_valid_lat", first_cyc - t0, 3);
            check("frame_len", fd_cyc - t0, 2816);
        end
    endtask

    int exp_lit;

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        mem_grant   = 1'b1;
        pixel_ready = 1'b1;
        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("idle");

        fb[0] = 8'h80;
        start_frame();
        run_frame(0, 5000);
        end_checks(1, 1'b1);

        fb[0]   = 8'h00;
        fb[8]   = 8'hFF;
        fb[255] = 8'h01;
        start_frame();
        run_frame(1, 5000);
        end_checks(9, 1'b0);

        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom_range(0, 255));
        fb[200] = 8'h00;
        start_frame();
        run_frame(2, 30000);
        exp_lit = 0;
        for (int i = 0; i < 256; i++) exp_lit += $countones(fb[i]);
        end_checks(exp_lit, 1'b0);

        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
        fb[8]   = 8'hFF;
        fb[255] = 8'h01;
        start_frame();
        run_frame(3, 5000);
        start_frame();
        run_frame(0, 5000);
        end_checks(9, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
